// File: rtl/regfile_dbg_master.sv
`default_nettype none
// regfile_dbg_master: debug command master driving a register file's read/write ports.
// Rev 1.0 - read, write, dump and clear commands with a valid/ready response channel.
module regfile_dbg_master #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned NB_OF_REGS        = 32,
  parameter int unsigned ADDRESS_BIT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [ADDRESS_BIT_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ADDRESS_BIT_WIDTH-1:0] rsp_addr,
  output logic                         rsp_last,
  output logic                         rsp_err,
  output logic [ADDRESS_BIT_WIDTH-1:0] rf_a1,
  input  logic [DATA_WIDTH-1:0]        rf_rd1,
  output logic [ADDRESS_BIT_WIDTH-1:0] rf_a3,
  output logic [DATA_WIDTH-1:0]        rf_wd3,
  output logic                         rf_we3,
  output logic                         core_stall
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [ADDRESS_BIT_WIDTH-1:0] LAST_IDX = ADDRESS_BIT_WIDTH'(NB_OF_REGS - 1);

  typedef enum logic [2:0] {IDLE, RD, WR, DUMP_RD, CLR, RESP} state_t;

  state_t                       state;
  logic [1:0]                   op;
  logic [ADDRESS_BIT_WIDTH-1:0] addr;
  logic [ADDRESS_BIT_WIDTH-1:0] index;
  logic [DATA_WIDTH-1:0]        wdata;
  logic                         addr_oob;

  assign addr_oob   = 32'(cmd_addr) >= NB_OF_REGS;
  assign cmd_ready  = en & rstn & (state == IDLE);
  assign core_stall = (state != IDLE);
  assign rf_we3     = en & ((state == WR) | (state == CLR));
  assign rf_a1      = (state == RD) ? addr : (state == DUMP_RD) ? index : '0;
  assign rf_a3      = (state == WR) ? addr : (state == CLR) ? index : '0;
  assign rf_wd3     = (state == WR) ? wdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      op        <= OP_RD;
      addr      <= '0;
      index     <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op    <= cmd_op;
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
            // Illegal reads/writes skip the register file and answer with an error at once.
            if ((cmd_op == OP_RD && addr_oob) ||
                (cmd_op == OP_WR && (addr_oob || cmd_addr == '0))) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_addr  <= cmd_addr;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (cmd_op == OP_RD) begin
              state <= RD;
            end else if (cmd_op == OP_WR) begin
              state <= WR;
            end else if (cmd_op == OP_DUMP) begin
              index <= '0;
              state <= DUMP_RD;
            end else begin
              index <= ADDRESS_BIT_WIDTH'(1);
              state <= CLR;
            end
          end
        end
        RD, WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= (state == RD) ? rf_rd1 : wdata;
          rsp_addr  <= addr;
          rsp_last  <= 1'b1;
          rsp_err   <= 1'b0;
        end
        DUMP_RD: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rd1;
          rsp_addr  <= index;
          rsp_last  <= (index == LAST_IDX);
          rsp_err   <= 1'b0;
        end
        CLR: begin
          if (index == LAST_IDX) begin
            index     <= '0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_addr  <= LAST_IDX;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b0;
          end else begin
            index <= index + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op == OP_DUMP && !rsp_last) begin
              index <= index + 1'b1;
              state <= DUMP_RD;
            end else begin
              index <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dbg_master.sv
`default_nettype none
// tb_regfile_dbg_master: directed, table-driven bench with a behavioural register file model.
// Rev 1.0
module tb_regfile_dbg_master;

  logic        clk, rstn, en;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic [4:0]  rf_a1, rf_a3;
  logic [31:0] rf_rd1, rf_wd3;
  logic        rf_we3, core_stall;

  regfile_dbg_master #(.DATA_WIDTH(32), .NB_OF_REGS(32), .ADDRESS_BIT_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .rf_we3(rf_we3), .core_stall(core_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model plus a log of every write strobe seen.
  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic        load;
  logic [4:0]  wlog_a [$];
  logic [31:0] wlog_d [$];

  assign rf_rd1 = mem[rf_a1];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h5A5A_0000 + i;
    end else if (rf_we3) begin
      mem[rf_a3] <= rf_wd3;
      wlog_a.push_back(rf_a3);
      wlog_d.push_back(rf_wd3);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
    if (!rsp_valid) chk("rsp_valid timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_we;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lat, nw;
    nw = wlog_a.size();
    send(v.op, v.addr, v.wdata);
    wait_rsp(lat);
    chk("latency", lat, v.exp_lat);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_addr", rsp_addr, v.addr);
    chk("rsp_last", rsp_last, 1);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("write strobes", wlog_a.size() - nw, v.exp_we);
    if (v.exp_we == 1 && wlog_a.size() > 0) begin
      chk("write addr", wlog_a[$], v.addr);
      chk("write data", wlog_d[$], v.wdata);
      exp_mem[v.addr] = v.wdata;
    end
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   lat;
    logic [4:0] a;

    vecs[0] = '{2'b01, 5'd9,  32'h0000_2004, 32'h0000_2004, 1'b0, 1, 2};
    vecs[1] = '{2'b00, 5'd9,  32'h0,         32'h0000_2004, 1'b0, 0, 2};
    vecs[2] = '{2'b01, 5'd0,  32'h0000_FFFF, 32'h0,         1'b1, 0, 1};
    vecs[3] = '{2'b00, 5'd0,  32'h0,         32'h5A5A_0000, 1'b0, 0, 2};
    vecs[4] = '{2'b01, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 2};
    vecs[5] = '{2'b00, 5'd31, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 2};
    vecs[6] = '{2'b00, 5'd17, 32'h0,         32'h5A5A_0011, 1'b0, 0, 2};

    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h5A5A_0000 + i;
    rstn = 1'b0; en = 1'b1; load = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'd0; cmd_wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset ctrl outputs", {26'd0, cmd_ready, rsp_valid, rf_we3, core_stall, rsp_last, rsp_err}, 32'd0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset addr outputs", {17'd0, rsp_addr, rf_a1, rf_a3}, 32'd0);
    chk("reset rf_wd3", rf_wd3, 0);
    cmd_valid = 1'b0; load = 1'b0; rstn = 1'b1;
    #1;
    chk("idle cmd_ready", cmd_ready, 1);
    chk("idle core_stall", core_stall, 0);
    en = 1'b0;
    #1 chk("en=0 cmd_ready", cmd_ready, 0);
    en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Dump with rsp_ready toggling and an enable gap at index 5.
    send(2'b10, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      wait_rsp(lat);
      chk("dump addr", rsp_addr, i);
      chk("dump data", rsp_data, exp_mem[i]);
      chk("dump last", rsp_last, (i == 31));
      if (i == 5) begin
        en = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("en0 rsp_valid held", rsp_valid, 1);
        chk("en0 rsp_addr held", rsp_addr, 5);
        chk("en0 rf_we3", rf_we3, 0);
        rsp_ready = 1'b0; en = 1'b1;
      end
      if (i % 2 == 1) begin
        @(negedge clk);
        chk("stall valid", rsp_valid, 1);
        chk("stall addr", rsp_addr, i);
        chk("stall data", rsp_data, exp_mem[i]);
      end
      ack();
    end
    @(negedge clk);
    chk("dump done stall", core_stall, 0);
    chk("dump done valid", rsp_valid, 0);

    // Full clear.
    wlog_a.delete(); wlog_d.delete();
    send(2'b11, 5'd0, 32'h0);
    wait_rsp(lat);
    chk("clear latency", lat, 32);
    chk("clear strobes", wlog_a.size(), 31);
    for (int i = 0; i < wlog_a.size(); i++) begin
      chk("clear write addr", wlog_a[i], i + 1);
      chk("clear write data", wlog_d[i], 0);
    end
    chk("clear rsp_addr", rsp_addr, 31);
    chk("clear rsp_data", rsp_data, 0);
    chk("clear rsp_last", rsp_last, 1);
    chk("clear rsp_err", rsp_err, 0);
    ack();
    for (int i = 1; i < 32; i++) exp_mem[i] = 32'h0;
    run_vec('{2'b00, 5'd9, 32'h0, 32'h0, 1'b0, 0, 2});
    run_vec('{2'b00, 5'd0, 32'h0, 32'h5A5A_0000, 1'b0, 0, 2});

    // Reset while clearing register 10.
    wlog_a.delete(); wlog_d.delete();
    send(2'b11, 5'd0, 32'h0);
    a = 5'd0;
    for (int n = 0; n < 100 && !(rf_we3 && rf_a3 == 5'd10); n++) @(negedge clk);
    chk("reached clear index 10", rf_a3, 10);
    rstn = 1'b0;
    #1;
    chk("midclear reset ctrl", {26'd0, cmd_ready, rsp_valid, rf_we3, core_stall, rsp_last, rsp_err}, 32'd0);
    chk("midclear reset addrs", {17'd0, rsp_addr, rf_a1, rf_a3}, 32'd0);
    chk("midclear reset data", rsp_data | rf_wd3, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post reset cmd_ready", cmd_ready, 1);
    chk("post reset core_stall", core_stall, 0);
    chk("midclear strobes", wlog_a.size(), 9);
    run_vec('{2'b00, 5'd31, 32'h0, 32'h0, 1'b0, 0, 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
